mem_bank_arbiter: RTL and testbench
===================================

MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, memory address width (2048 entries).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a_req / b_req  input  1  requester A / B command valid; held with its fields until granted.
REQ-006 a_we / b_we  input  1  1 = write command, 0 = read command.
REQ-007 a_addr / b_addr  input  ADDR_W  command address.
REQ-008 a_wdata / b_wdata  input  DATA_W  write data, ignored for reads.
REQ-009 a_gnt / b_gnt  output  1  combinational; high in the cycle the command is accepted.
REQ-010 a_rvalid / b_rvalid  output  1  registered; one-cycle pulse marking read data return.
REQ-011 a_rdata / b_rdata  output  DATA_W  read data, meaningful only while the matching rvalid is high.
REQ-012 mem_ren, mem_wen  output  1  registered read / write enables to the multi-bank memory.
REQ-013 mem_raddr, mem_waddr  output  ADDR_W  registered read / write addresses.
REQ-014 mem_din  output  DATA_W  registered write data.
REQ-015 mem_dout  input  DATA_W  memory read data, valid the cycle after the memory samples mem_ren.

Function
REQ-016 Per cycle: at most one read grant and one write grant, forwarded to the memory's independent read and write ports.
REQ-017 One requester with req high: its command is granted that cycle, unless blocked by REQ-020.
REQ-018 Both requesters issue the same command type: round-robin.
- A separate priority pointer is kept for reads (rd_ptr) and for writes (wr_ptr).
- The pointer selects the winner; after a grant it toggles to favour the loser.
REQ-019 One read and one write from different requesters: both are granted in the same cycle.
REQ-020 Hazard, same cycle, read addr == write addr:
- Only the write is granted.
- The read is held with gnt low and is granted in a later cycle.
- rd_ptr does not change.
REQ-021 Pipeline stage: on posedge after a grant cycle N, mem_* carry the granted command.
- The enable is 0 when there is no grant of that type.
- The address and data registers hold their previous values when the enable is 0.
REQ-022 Read latency:
- The memory samples the command at the end of cycle N+1.
- mem_dout is valid in cycle N+2.
- The owner's rvalid is high in cycle N+2; that rdata = mem_dout.
REQ-023 Read-owner tag: a 2-stage shift register records the owner of each granted read.
- Reads may be granted back to back.
- One rvalid returns per granted read, in grant order.
REQ-024 a_rvalid and b_rvalid are never high in the same cycle.
REQ-025 Read after write, same address, write granted in cycle N and read granted in cycle N+1 or later: the read returns the new data.
REQ-026 A requester with req low receives gnt low.
REQ-027 Dropping req before a grant is a protocol violation; behaviour is undefined.
REQ-028 Address values are forwarded unchanged; all 2^ADDR_W addresses are legal, with no wrap logic.

Reset
REQ-029 While rst is high at posedge:
- mem_ren = mem_wen = 0.
- mem_raddr = mem_waddr = 0, mem_din = 0.
- a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0.
- The read-owner tag pipeline is cleared.
- rd_ptr and wr_ptr = A.
REQ-030 While rst is high, a_gnt and b_gnt are 0.
REQ-031 Reset mid-operation discards in-flight reads; no rvalid follows for them.

Verification
REQ-032 After reset, A writes addr 60 data 66, then A reads addr 60 -> a_gnt high each request cycle; a_rvalid exactly 2 cycles after the read grant with a_rdata=66.
REQ-033 A and B both write in the same cycle (A addr 100 data 120, B addr 101 data 7), then both read back -> A granted first, B in the next cycle; wr_ptr toggles; reads return 120 to A and 7 to B, in grant order.
REQ-034 A writes addr 200 data 5 while B reads addr 200 in the same cycle -> only a_gnt is high; b_gnt follows one cycle later; B's read returns 5.
REQ-035 A reads addr 10 and B writes addr 20 in the same cycle -> both gnts high; mem_ren and mem_wen are both high the next cycle.
REQ-036 Continuous reads from both requesters for 8 cycles -> grants alternate A,B,A,B...; 8 rvalid pulses, never both high at once.
REQ-037 rst asserted one cycle after a read grant -> no rvalid follows; all outputs hold their reset values while rst is high.

Source files
------------

// File: rtl/mem_bank_arbiter.sv
// Two-requester arbiter feeding a memory with independent read and write ports.
// Round-robin per command type, write-wins on same-address hazards, tagged read return.
module mem_bank_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

  sel_t              rd_ptr;
  sel_t              wr_ptr;
  logic              a_rd, b_rd, a_wr, b_wr;
  logic              wr_gnt_a, wr_gnt_b, wr_any;
  logic              rd_pick_a, rd_pick_b, hazard;
  logic              rd_gnt_a, rd_gnt_b, rd_any;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              tag_vld;
  logic              tag_own_b;

  // Arbitration: pick one writer and one reader, then drop the reader on an address clash.
  always_comb begin
    a_rd      = a_req & ~a_we;
    b_rd      = b_req & ~b_we;
    a_wr      = a_req & a_we;
    b_wr      = b_req & b_we;
    wr_gnt_a  = 1'b0;
    wr_gnt_b  = 1'b0;
    rd_pick_a = 1'b0;
    rd_pick_b = 1'b0;
    if (rst) begin
      wr_gnt_a  = 1'b0;
      wr_gnt_b  = 1'b0;
    end else if (a_wr && b_wr) begin
      wr_gnt_a  = (wr_ptr == SEL_A);
      wr_gnt_b  = (wr_ptr == SEL_B);
    end else begin
      wr_gnt_a  = a_wr;
      wr_gnt_b  = b_wr;
    end
    if (rst) begin
      rd_pick_a = 1'b0;
      rd_pick_b = 1'b0;
    end else if (a_rd && b_rd) begin
      rd_pick_a = (rd_ptr == SEL_A);
      rd_pick_b = (rd_ptr == SEL_B);
    end else begin
      rd_pick_a = a_rd;
      rd_pick_b = b_rd;
    end
    wr_any   = wr_gnt_a | wr_gnt_b;
    wr_addr  = wr_gnt_b ? b_addr : a_addr;
    wr_data  = wr_gnt_b ? b_wdata : a_wdata;
    rd_addr  = rd_pick_b ? b_addr : a_addr;
    hazard   = wr_any & (rd_pick_a | rd_pick_b) & (rd_addr == wr_addr);
    rd_gnt_a = rd_pick_a & ~hazard;
    rd_gnt_b = rd_pick_b & ~hazard;
    rd_any   = rd_gnt_a | rd_gnt_b;
    a_gnt    = wr_gnt_a | rd_gnt_a;
    b_gnt    = wr_gnt_b | rd_gnt_b;
  end

  // Pointers, memory command stage and the two-deep read-owner tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= SEL_A;
      wr_ptr    <= SEL_A;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_raddr <= {ADDR_W{1'b0}};
      mem_waddr <= {ADDR_W{1'b0}};
      mem_din   <= {DATA_W{1'b0}};
      tag_vld   <= 1'b0;
      tag_own_b <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
    end else begin
      if (a_rd && b_rd) begin
        rd_ptr <= rd_gnt_a ? SEL_B : SEL_A;
      end else begin
        rd_ptr <= rd_ptr;
      end
      if (a_wr && b_wr) begin
        wr_ptr <= wr_gnt_a ? SEL_B : SEL_A;
      end else begin
        wr_ptr <= wr_ptr;
      end
      mem_ren <= rd_any;
      mem_wen <= wr_any;
      if (rd_any) begin
        mem_raddr <= rd_addr;
      end else begin
        mem_raddr <= mem_raddr;
      end
      if (wr_any) begin
        mem_waddr <= wr_addr;
        mem_din   <= wr_data;
      end else begin
        mem_waddr <= mem_waddr;
        mem_din   <= mem_din;
      end
      tag_vld   <= rd_any;
      tag_own_b <= rd_gnt_b;
      a_rvalid  <= tag_vld & ~tag_own_b;
      b_rvalid  <= tag_vld & tag_own_b;
    end
  end

  // Memory data arrives in the rvalid cycle, so it is steered rather than registered.
  always_comb begin
    a_rdata = a_rvalid ? mem_dout : {DATA_W{1'b0}};
    b_rdata = b_rvalid ? mem_dout : {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: directed scenarios plus random traffic, checked
// against a command-level reference model with a shadow memory and a return queue.
module tb_mem_bank_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  mem_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Environment memory: one-cycle registered read port, cleared while rst is high.
  logic [DW-1:0] bmem [0:DEPTH-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bmem[i] <= '0;
    end else begin
      if (mem_wen) bmem[mem_waddr] <= mem_din;
      if (mem_ren) mem_dout <= bmem[mem_raddr];
    end
  end

  // Requester command slots (index 0 = A, 1 = B); a slot stays pending until granted.
  bit            pend [2];
  bit            pwe  [2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pdata[2];

  // Reference model state.
  typedef struct { int due; bit own_b; logic [DW-1:0] data; } rd_t;
  rd_t           exp_q[$];
  logic [DW-1:0] shadow [0:DEPTH-1];
  bit            rd_fav_b, wr_fav_b;
  bit            e_ren, e_wen;
  logic [AW-1:0] e_raddr, e_waddr;
  logic [DW-1:0] e_din;
  int            n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_cmd(input int who, input bit we, input int addr, input int data);
    pend[who]  = 1'b1;
    pwe[who]   = we;
    paddr[who] = AW'(addr);
    pdata[who] = DW'(data);
  endtask

  task automatic run_cycle(input bit rnd, input bit r);
    bit ea, eb, wa, wb, ra, rb, wg, rg, w_own, r_own, ga, gb;
    logic [DW-1:0] ed;
    rd_t e;
    @(posedge clk);
    #1;
    cyc++;
    // registered outputs produced by the previous cycle's decisions
    check_eq("mem_ren", mem_ren, e_ren);
    check_eq("mem_wen", mem_wen, e_wen);
    check_eq("mem_raddr", mem_raddr, e_raddr);
    check_eq("mem_waddr", mem_waddr, e_waddr);
    check_eq("mem_din", mem_din, e_din);
    ea = 1'b0; eb = 1'b0; ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      ea = !e.own_b;
      eb = e.own_b;
      ed = e.data;
    end
    check_eq("a_rvalid", a_rvalid, ea);
    check_eq("b_rvalid", b_rvalid, eb);
    if (ea) check_eq("a_rdata", a_rdata, ed);
    if (eb) check_eq("b_rdata", b_rdata, ed);
    if (rst) begin
      check_eq("a_rdata_rst", a_rdata, 0);
      check_eq("b_rdata_rst", b_rdata, 0);
    end
    // new stimulus
    if (rnd) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i]  = 1'b1;
          pwe[i]   = 1'($urandom_range(0, 1));
          paddr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
          pdata[i] = DW'($urandom);
        end
      end
    end
    rst     = r;
    a_req   = pend[0]; a_we = pwe[0]; a_addr = paddr[0]; a_wdata = pdata[0];
    b_req   = pend[1]; b_we = pwe[1]; b_addr = paddr[1]; b_wdata = pdata[1];
    #1;
    // reference decision for this cycle
    wg = 1'b0; rg = 1'b0; w_own = 1'b0; r_own = 1'b0;
    if (!rst) begin
      wa = pend[0] && pwe[0];  wb = pend[1] && pwe[1];
      ra = pend[0] && !pwe[0]; rb = pend[1] && !pwe[1];
      if (wa && wb) begin
        wg = 1'b1; w_own = wr_fav_b; wr_fav_b = !w_own;
      end else if (wa || wb) begin
        wg = 1'b1; w_own = wb;
      end
      if (ra && rb) begin
        rg = 1'b1; r_own = rd_fav_b; rd_fav_b = !r_own;
      end else if (ra || rb) begin
        r_own = rb;
        rg = !(wg && paddr[r_own] == paddr[w_own]);
      end
    end
    ga = (wg && !w_own) || (rg && !r_own);
    gb = (wg && w_own) || (rg && r_own);
    check_eq("a_gnt", a_gnt, ga);
    check_eq("b_gnt", b_gnt, gb);
    if (rst) begin
      exp_q.delete();
      rd_fav_b = 1'b0; wr_fav_b = 1'b0;
      e_ren = 1'b0; e_wen = 1'b0; e_raddr = '0; e_waddr = '0; e_din = '0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    end else begin
      e_ren = rg;
      e_wen = wg;
      if (rg) begin
        e_raddr = paddr[r_own];
        exp_q.push_back('{due: cyc + 2, own_b: r_own, data: shadow[paddr[r_own]]});
        pend[r_own] = 1'b0;
      end
      if (wg) begin
        e_waddr = paddr[w_own];
        e_din   = pdata[w_own];
        shadow[paddr[w_own]] = pdata[w_own];
        pend[w_own] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end
    rd_fav_b = 1'b0; wr_fav_b = 1'b0;
    e_ren = 1'b0; e_wen = 1'b0; e_raddr = '0; e_waddr = '0; e_din = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);

    // A writes then reads back
    set_cmd(0, 1'b1, 60, 66);
    run_cycle(1'b0, 1'b0);
    set_cmd(0, 1'b0, 60, 0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);

    // contending writes, then contending reads
    set_cmd(0, 1'b1, 100, 120);
    set_cmd(1, 1'b1, 101, 7);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);
    set_cmd(0, 1'b0, 100, 0);
    set_cmd(1, 1'b0, 101, 0);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

    // same-address hazard: write wins, read retried
    set_cmd(0, 1'b1, 200, 5);
    set_cmd(1, 1'b0, 200, 0);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

    // read and write to different addresses together
    set_cmd(0, 1'b0, 10, 0);
    set_cmd(1, 1'b1, 20, 9);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);

    // continuous reads from both requesters
    for (int i = 0; i < 8; i++) begin
      if (!pend[0]) set_cmd(0, 1'b0, 100 + (i % 2), 0);
      if (!pend[1]) set_cmd(1, 1'b0, 101 - (i % 2), 0);
      run_cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) run_cycle(1'b1, ($urandom_range(0, 149) == 0));
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0);

    // reset right after a read grant discards the read
    set_cmd(0, 1'b0, 60, 0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
